// File: rtl/ow_pkg.sv
// Shared FSM encoding and default timing for the 1-wire master arbiter.
package ow_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRstLow,
    StRstWait,
    StRstRec,
    StBitLow,
    StBitRel,
    StBitRec,
    StDone
  } ow_state_e;

  localparam int unsigned CntW          = 16;
  localparam int unsigned DefRstLowCyc  = 24000;
  localparam int unsigned DefPresSmpCyc = 3500;
  localparam int unsigned DefLow0Cyc    = 3000;
  localparam int unsigned DefLow1Cyc    = 300;
  localparam int unsigned DefSlotCyc    = 3500;
  localparam int unsigned DefRecCyc     = 100;

endpackage

// File: rtl/ow_rr_arb.sv
// Two-requester round-robin arbiter; ptr=0 favours requester 0, ptr=1 favours requester 1.
module ow_rr_arb (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (ptr) begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end else begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end

endmodule

// File: rtl/ow_master_arb.sv
// Two-port 1-wire master: round-robin grant, then a reset/presence or byte-write sequence.
// Define OW_PRESENCE_EN to sample the presence pulse; otherwise presence reads constant 1.
module ow_master_arb
  import ow_pkg::*;
#(
  parameter int unsigned RST_LOW_CYC     = DefRstLowCyc,
  parameter int unsigned PRES_SAMPLE_CYC = DefPresSmpCyc,
  parameter int unsigned LOW0_CYC        = DefLow0Cyc,
  parameter int unsigned LOW1_CYC        = DefLow1Cyc,
  parameter int unsigned SLOT_CYC        = DefSlotCyc,
  parameter int unsigned REC_CYC         = DefRecCyc
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] gnt,
  output logic       done,
  output logic       presence,
  output logic       busy,
  input  logic       bus_in,
  output logic       bus_oe
);

  // Terminal counts: each phase ends on the cycle whose count equals its length minus one.
  localparam logic [CntW-1:0] RstLowLast  = CntW'(RST_LOW_CYC - 1);
  localparam logic [CntW-1:0] RstWaitLast = CntW'(PRES_SAMPLE_CYC - 1);
  localparam logic [CntW-1:0] RstRecLast  = CntW'(RST_LOW_CYC - PRES_SAMPLE_CYC - 1);
  localparam logic [CntW-1:0] Low0Last    = CntW'(LOW0_CYC - 1);
  localparam logic [CntW-1:0] Low1Last    = CntW'(LOW1_CYC - 1);
  localparam logic [CntW-1:0] Rel0Last    = CntW'(SLOT_CYC - LOW0_CYC - 1);
  localparam logic [CntW-1:0] Rel1Last    = CntW'(SLOT_CYC - LOW1_CYC - 1);
  localparam logic [CntW-1:0] BitRecLast  = CntW'(REC_CYC - 1);

  ow_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            ptr_q, ptr_d;
  logic [1:0]      arb_gnt;
  logic            sel_cmd;
  logic            cur_bit;

  ow_rr_arb u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  assign sel_cmd = arb_gnt[1] ? cmd[1] : cmd[0];
  assign cur_bit = data_q[bit_q];

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    data_d  = data_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d   = arb_gnt;
          ptr_d   = arb_gnt[0];
          data_d  = arb_gnt[1] ? wdata1 : wdata0;
          bit_d   = 3'd0;
          state_d = sel_cmd ? StRstLow : StBitLow;
        end
      end
      StRstLow:  if (cnt_q == RstLowLast)  state_d = StRstWait;
      StRstWait: if (cnt_q == RstWaitLast) state_d = StRstRec;
      StRstRec:  if (cnt_q == RstRecLast)  state_d = StDone;
      StBitLow:  if (cnt_q == (cur_bit ? Low1Last : Low0Last)) state_d = StBitRel;
      StBitRel:  if (cnt_q == (cur_bit ? Rel1Last : Rel0Last)) state_d = StBitRec;
      StBitRec: begin
        if (cnt_q == BitRecLast) begin
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? StDone : StBitLow;
        end
      end
      StDone: begin
        gnt_d   = 2'b00;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      data_q  <= 8'd0;
      gnt_q   <= 2'b00;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = (state_q == StDone);
  assign busy   = (state_q != StIdle);
  assign bus_oe = (state_q == StRstLow) || (state_q == StBitLow);

`ifdef OW_PRESENCE_EN
  logic pres_q;

  // Sample point is exactly PRES_SAMPLE_CYC cycles after the line is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pres_q <= 1'b0;
    end else if (state_q == StRstRec && cnt_q == '0) begin
      pres_q <= ~bus_in;
    end
  end

  assign presence = pres_q;
`else
  logic unused_bus_in;

  assign unused_bus_in = bus_in;
  assign presence      = 1'b1;
`endif

endmodule

// File: doc/ow_master_arb.md
OW_MASTER_ARB -- requirements
Module: ow_master_arb

Interface
REQ-001 SHALL have parameter RST_LOW_CYC, default 24000, meaning bus-low cycles of the reset pulse.
REQ-002 SHALL have parameter PRES_SAMPLE_CYC, default 3500, meaning cycles after reset release at which presence is sampled.
REQ-003 SHALL have parameter LOW0_CYC, default 3000, meaning low time of a write-0 slot.
REQ-004 SHALL have parameter LOW1_CYC, default 300, meaning low time of a write-1 slot.
REQ-005 SHALL have parameter SLOT_CYC, default 3500, meaning total bit-slot length; REC_CYC, default 100, meaning inter-slot recovery.
REQ-006 SHALL have ports: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: req  in  2  per-requester request; cmd  in  2  per-requester command, 1=reset/presence, 0=write byte.
REQ-008 SHALL have ports: wdata0, wdata1  in  8 each  byte to write.
REQ-009 SHALL have ports: gnt  out  2  one-hot grant; done  out  1  one-cycle completion pulse; presence  out  1  last presence result; busy  out  1  operation in progress.
REQ-010 SHALL have ports: bus_in  in  1  sampled 1-wire line; bus_oe  out  1  1=drive line low (open drain).

Function
REQ-011 SHALL implement states IDLE, RST_LOW, RST_WAIT, RST_REC, BIT_LOW, BIT_REL, BIT_REC, DONE.
REQ-012 In IDLE with any req set, SHALL grant one requester, latch its cmd and wdata, and leave IDLE on the next clock.
REQ-013 Arbitration SHALL be round-robin: if both req bits are set, grant the requester not granted last; the pointer favours requester 0 after reset.
REQ-014 gnt SHALL stay asserted from the grant until the done cycle inclusive, then clear.
REQ-015 Dropping req mid-operation SHALL NOT abort; the operation completes and done pulses.
REQ-016 Reset command: RST_LOW drives bus_oe=1 for RST_LOW_CYC cycles; RST_WAIT releases and samples at PRES_SAMPLE_CYC; RST_REC releases for RST_LOW_CYC minus PRES_SAMPLE_CYC cycles; then DONE.
REQ-017 Presence SHALL be registered as NOT bus_in at the sample cycle and held until the next reset command completes.
REQ-018 Write command: 8 slots, LSB first; BIT_LOW drives low for LOW0_CYC (bit 0) or LOW1_CYC (bit 1); BIT_REL releases until SLOT_CYC total; BIT_REC releases REC_CYC cycles; then next bit, or DONE after bit 7.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE; a new grant is possible the following cycle.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 Cycle counter SHALL be 16-bit unsigned, cleared on every state change; parameters SHALL satisfy LOW1_CYC < LOW0_CYC < SLOT_CYC and PRES_SAMPLE_CYC < RST_LOW_CYC.

Reset
REQ-022 rst_n low SHALL force state IDLE, gnt=0, done=0, presence=0, busy=0, bus_oe=0, and clear the counter, bit index and RR pointer, immediately and without a clock.
REQ-023 Reset asserted mid-slot SHALL release the bus at once; the interrupted operation SHALL NOT report done.

Configuration
REQ-024 With OW_PRESENCE_EN defined, presence SHALL be sampled per REQ-017.
REQ-025 Without OW_PRESENCE_EN, presence SHALL be constant 1, no sampling logic is built, and reset-sequence timing is unchanged.

Structure
REQ-026 State encodings and default timing constants SHALL reside in shared package ow_pkg.
REQ-027 The round-robin arbiter SHALL be sub-module ow_rr_arb (req, pointer in; one-hot grant out).

Verification
REQ-028 req=01, cmd=01 -> bus_oe high 24000 cycles; bench pulls bus_in low at release+3500 -> presence=1, done pulses at release+24000.
REQ-029 req=01, cmd=00, wdata0=0xA5 -> low times 300,3000,300,3000,3000,300,3000,300 cycles; slots 3600 cycles apart; one done.
REQ-030 req=11 held across three ops -> grant order 01,10,01.
REQ-031 rst_n low at cycle 1000 of a write-0 slot -> bus_oe=0 immediately, gnt=00, no done.
REQ-032 Requester 1 drops req after grant -> byte still completes, done pulses, gnt cleared.
REQ-033 Build without OW_PRESENCE_EN, reset command, bus_in held high -> presence=1.
